// File: rtl/rf_writeback_ctrl_if.sv
// rf_writeback_ctrl_if: result channels from ALU/load and the register file write port
interface rf_writeback_ctrl_if #(parameter int DW = 8, parameter int AW = 3);
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          rf_write;
  logic [AW-1:0] rf_da;
  logic [DW-1:0] rf_din;
  modport master (output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
                  input alu_ready, ld_ready, rf_write, rf_da, rf_din);
  modport slave  (input alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
                  output alu_ready, ld_ready, rf_write, rf_da, rf_din);
endinterface

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: in-order writeback FIFO with busy scoreboard driving the register file write port
module rf_writeback_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  rf_writeback_ctrl_if.slave           bus,
  input  logic                         wb_hold,
  input  logic                         issue_val,
  input  logic [AW-1:0]                issue_rd,
  input  logic [AW-1:0]                rs1_addr,
  input  logic [AW-1:0]                rs2_addr,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic [$clog2(DEPTH+1)-1:0]   wb_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NR = 2**AW;
  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [NR-1:0]    busy, set_m, clr_m;
  logic             full, take_ld, take_alu, push, pop;
  logic [AW-1:0]    push_rd;
  logic [DW-1:0]    push_data;
  always_comb begin
    full      = wb_count == CW'(DEPTH);
    take_ld   = bus.ld_valid & ~full;
    take_alu  = bus.alu_valid & ~full & ~bus.ld_valid;
    push_rd   = take_ld ? bus.ld_rd : bus.alu_rd;
    push_data = take_ld ? bus.ld_data : bus.alu_data;
    push      = (take_ld | take_alu) & (push_rd != '0);
    pop       = (wb_count != '0) & ~wb_hold;
    set_m     = issue_val ? NR'(1) << issue_rd : '0;
    clr_m     = bus.rf_write ? NR'(1) << bus.rf_da : '0;
  end
  assign bus.ld_ready  = ~full;
  assign bus.alu_ready = ~full & ~bus.ld_valid;
  assign rs1_busy      = busy[rs1_addr];
  assign rs2_busy      = busy[rs2_addr];
  always_ff @(posedge clk)
    if (push) mem[wp] <= {push_rd, push_data};
  // set is OR-ed after the clear so a re-issue in the retiring cycle keeps the register busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp           <= '0;
      rp           <= '0;
      wb_count     <= '0;
      busy         <= '0;
      bus.rf_write <= 1'b0;
      bus.rf_da    <= '0;
      bus.rf_din   <= '0;
    end else begin
      wp           <= wp + PW'(push);
      rp           <= rp + PW'(pop);
      wb_count     <= wb_count + CW'(push) - CW'(pop);
      busy         <= ((busy & ~clr_m) | set_m) & ~NR'(1);
      bus.rf_write <= pop;
      if (pop) {bus.rf_da, bus.rf_din} <= mem[rp];
    end
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb_rf_writeback_ctrl: directed stimulus with a queue scoreboard checked by an independent write monitor
module tb_rf_writeback_ctrl;
  logic       clk = 0, rst_n = 1;
  logic       wb_hold = 0, issue_val = 0, rs1_busy, rs2_busy;
  logic [2:0] issue_rd = 0, rs1_addr = 0, rs2_addr = 0;
  logic [2:0] wb_count;
  int         errors = 0, checks = 0;
  typedef struct packed {logic [2:0] rd; logic [7:0] d;} exp_t;
  exp_t q[$];
  rf_writeback_ctrl_if #(.DW(8), .AW(3)) bus ();
  rf_writeback_ctrl #(.DW(8), .AW(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .wb_hold(wb_hold), .issue_val(issue_val),
    .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .wb_count(wb_count));
  always #5 clk = ~clk;
  task automatic chk(string n, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, expv);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic alu(logic v, logic [2:0] rd, logic [7:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask
  always @(negedge clk)
    if (rst_n && bus.rf_write) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got da=%0h din=%0h expected none", bus.rf_da, bus.rf_din);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_da", bus.rf_da, e.rd);
        chk("wb_din", bus.rf_din, e.d);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bit got;
    alu(0, 0, 0);
    bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_write", bus.rf_write, 0);
    chk("rst_da", bus.rf_da, 0);
    chk("rst_din", bus.rf_din, 0);
    chk("rst_count", wb_count, 0);
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_ld_ready", bus.ld_ready, 1);
    #10 rst_n = 1;
    step();
    // single ALU result latency
    alu(1, 3, 8'h5A); q.push_back({3'd3, 8'h5A});
    @(negedge clk) chk("t2_ready", bus.alu_ready, 1);
    step(); alu(0, 0, 0);
    @(negedge clk) chk("t2_e0", bus.rf_write, 0);
    step();
    @(negedge clk) begin
      chk("t2_e1", bus.rf_write, 1);
      chk("t2_da", bus.rf_da, 3);
      chk("t2_din", bus.rf_din, 8'h5A);
    end
    step();
    @(negedge clk) chk("t2_e2", bus.rf_write, 0);
    // load beats ALU
    step();
    bus.ld_valid = 1; bus.ld_rd = 2; bus.ld_data = 8'h22; alu(1, 1, 8'h11);
    q.push_back({3'd2, 8'h22});
    @(negedge clk) begin
      chk("t3_alu_ready", bus.alu_ready, 0);
      chk("t3_ld_ready", bus.ld_ready, 1);
    end
    step(); bus.ld_valid = 0;
    q.push_back({3'd1, 8'h11});
    @(negedge clk) chk("t3_alu_ready2", bus.alu_ready, 1);
    step(); alu(0, 0, 0);
    @(negedge clk) begin chk("t3_w1", bus.rf_write, 1); chk("t3_w1_da", bus.rf_da, 2); end
    step();
    @(negedge clk) begin chk("t3_w2", bus.rf_write, 1); chk("t3_w2_da", bus.rf_da, 1); end
    step();
    @(negedge clk) chk("t3_idle", bus.rf_write, 0);
    // fill under hold
    wb_hold = 1;
    for (int i = 0; i < 4; i++) begin
      step(); alu(1, 3'(i + 1), 8'(8'h40 + i));
      q.push_back({3'(i + 1), 8'(8'h40 + i)});
      @(negedge clk) chk("t4_ready", bus.alu_ready, 1);
    end
    step(); alu(1, 5, 8'h44);
    @(negedge clk) begin
      chk("t4_count", wb_count, 4);
      chk("t4_alu_full", bus.alu_ready, 0);
      chk("t4_ld_full", bus.ld_ready, 0);
    end
    repeat (2) step();
    @(negedge clk) begin chk("t4_hold_write", bus.rf_write, 0); chk("t4_hold_count", wb_count, 4); end
    step(); wb_hold = 0;
    @(negedge clk) chk("t4_full_on_pop", bus.alu_ready, 0);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      @(negedge clk) if (bus.alu_ready) begin got = 1; q.push_back({3'd5, 8'h44}); end
    end
    chk("t4_accept5", got, 1);
    step(); alu(0, 0, 0);
    repeat (8) step();
    chk("t4_drained", q.size(), 0);
    // rd 0 is swallowed
    alu(1, 0, 8'hFF);
    @(negedge clk) chk("t5_ready", bus.alu_ready, 1);
    step(); alu(0, 0, 0);
    @(negedge clk) chk("t5_count", wb_count, 0);
    repeat (3) step();
    @(negedge clk) chk("t5_nowrite", bus.rf_write, 0);
    // scoreboard set/clear
    step(); issue_val = 1; issue_rd = 5; rs1_addr = 5; rs2_addr = 0;
    @(negedge clk) chk("t6_pre", rs1_busy, 0);
    step(); issue_val = 0;
    @(negedge clk) begin chk("t6_set", rs1_busy, 1); chk("t6_r0", rs2_busy, 0); end
    alu(1, 5, 8'h77); q.push_back({3'd5, 8'h77});
    step(); alu(0, 0, 0);
    step();
    @(negedge clk) begin chk("t6_wr", bus.rf_write, 1); chk("t6_busy_wr", rs1_busy, 1); end
    issue_val = 1; issue_rd = 5;
    step(); issue_val = 0;
    @(negedge clk) chk("t6_set_wins", rs1_busy, 1);
    alu(1, 5, 8'h78); q.push_back({3'd5, 8'h78});
    step(); alu(0, 0, 0);
    step();
    step();
    @(negedge clk) chk("t6_clear", rs1_busy, 0);
    // reset mid-stream
    wb_hold = 1;
    step(); issue_val = 1; issue_rd = 4; rs1_addr = 4;
    alu(1, 1, 8'hA1); q.push_back({3'd1, 8'hA1});
    step(); issue_val = 0; alu(1, 2, 8'hA2); q.push_back({3'd2, 8'hA2});
    step(); alu(1, 3, 8'hA3); q.push_back({3'd3, 8'hA3});
    step(); alu(0, 0, 0); wb_hold = 0;
    @(negedge clk) chk("t1_count3", wb_count, 3);
    step();
    @(negedge clk) begin chk("t1_wr", bus.rf_write, 1); chk("t1_busy", rs1_busy, 1); end
    #1 rst_n = 0;
    #1 begin
      chk("t1_write0", bus.rf_write, 0);
      chk("t1_count0", wb_count, 0);
      chk("t1_busy0", rs1_busy, 0);
    end
    q.delete();
    #10 rst_n = 1;
    repeat (10) step();
    chk("t1_nowrites", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
